// File: rtl/instr_encoder_if.sv
// Command/instruction bundle between host, encoder and consumer.
// master = encoder side, slave = host/consumer side.
interface instr_encoder_if #(
    parameter int AW = 2
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [1:0]    cmd_id;
    logic [2:0]    cmd_row;
    logic [2:0]    cmd_col;
    logic [7:0]    cmd_d0;
    logic [7:0]    cmd_d1;
    logic [7:0]    cmd_scalar;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [AW:0]   fifo_count;
    logic          cmd_err;
    logic [15:0]   issued_cnt;

    modport master (
        input  cmd_valid, cmd_op, cmd_id, cmd_row, cmd_col,
        input  cmd_d0, cmd_d1, cmd_scalar, instr_ready,
        output cmd_ready, instr_valid, instr, fifo_count,
        output cmd_err, issued_cnt
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_id, cmd_row, cmd_col,
        output cmd_d0, cmd_d1, cmd_scalar, instr_ready,
        input  cmd_ready, instr_valid, instr, fifo_count,
        input  cmd_err, issued_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs coprocessor commands into 32-bit words and queues them
// in a small FIFO for issue over a valid/ready channel.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.master bus
);
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic [15:0]   issued_q, issued_d;
    logic [31:0]   word_d;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;

    // Field packing; scalar ops use a compact layout, others carry row/col/data
    always_comb begin
        word_d = '0;
        word_d[3:0] = bus.cmd_op;
        if (bus.cmd_op[3]) begin
            word_d[11:4] = bus.cmd_scalar;
        end else begin
            word_d[6:4]   = bus.cmd_col;
            word_d[9:7]   = bus.cmd_row;
            word_d[11:10] = bus.cmd_id;
            word_d[19:12] = bus.cmd_d0;
            word_d[27:20] = bus.cmd_d1;
        end
    end

    assign legal = bus.cmd_op[3] |
                   ((bus.cmd_row <= 3'd4) & (bus.cmd_col <= 3'd4));

    assign bus.cmd_ready   = (count_q != (AW+1)'(DEPTH));
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = bus.instr_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.fifo_count  = count_q;
    assign bus.cmd_err     = err_q;
    assign bus.issued_cnt  = issued_q;

    assign accept = bus.cmd_valid & bus.cmd_ready;
    assign push   = accept & legal;
    assign pop    = bus.instr_valid & bus.instr_ready;

    // Next-state for pointers, occupancy, error pulse and issue counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        issued_d = issued_q;
        err_d    = accept & ~legal;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            issued_d = issued_q + 16'd1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            issued_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            issued_q <= issued_d;
        end
    end

    // Storage; stale entries are harmless since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= word_d;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a queue-based scoreboard
// and an independent monitor on the instruction channel.
module tb_instr_encoder;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   pops;
    logic [31:0] exp_q[$];

    instr_encoder_if #(.AW(2)) bus();

    instr_encoder #(.DEPTH(4), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every word taken by the consumer must match the queue head
    always @(negedge clk) begin
        if (!reset && bus.instr_valid && bus.instr_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL monitor: unexpected word %h", bus.instr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.instr !== e) begin
                    miscompares++;
                    $display("FAIL order: got %h expected %h", bus.instr, e);
                end
            end
            pops++;
        end
    end

    task automatic send(input logic [3:0] op, input logic [1:0] id,
                        input logic [2:0] row, input logic [2:0] col,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] sc, input logic [31:0] exp,
                        input bit pushes);
        int n;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_id     = id;
        bus.cmd_row    = row;
        bus.cmd_col    = col;
        bus.cmd_d0     = d0;
        bus.cmd_d1     = d1;
        bus.cmd_scalar = sc;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: cmd_ready stuck %b want 1", bus.cmd_ready);
        end else if (pushes) begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n;
        n = 0;
        bus.instr_ready = 1'b1;
        while (bus.fifo_count != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_count", 32'(bus.fifo_count), 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        pops = 0;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_id = '0;
        bus.cmd_row = '0;
        bus.cmd_col = '0;
        bus.cmd_d0 = '0;
        bus.cmd_d1 = '0;
        bus.cmd_scalar = '0;
        bus.instr_ready = 1'b0;
        cycles(3);
        reset = 1'b0;
        pops = 0;
        #1;

        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_issued", 32'(bus.issued_cnt), 32'd0);
        chk("rst_err", 32'(bus.cmd_err), 32'd0);

        // Basic packing with consumer always ready
        bus.instr_ready = 1'b1;
        send(4'h1, 2'd2, 3'd3, 3'd1, 8'hAB, 8'hCD, 8'h00, 32'h0CDAB991, 1);
        chk("t1_valid", 32'(bus.instr_valid), 32'd1);
        chk("t1_instr", bus.instr, 32'h0CDAB991);
        cycles(1);
        chk("t1_valid_drop", 32'(bus.instr_valid), 32'd0);
        chk("t1_issued", 32'(bus.issued_cnt), 32'd1);

        // Scalar op ignores row/col/id/data even if out of range
        send(4'h8, 2'd3, 3'd7, 3'd6, 8'hFF, 8'hEE, 8'h7F, 32'h000007F8, 1);
        chk("t2_instr", bus.instr, 32'h000007F8);
        chk("t2_err", 32'(bus.cmd_err), 32'd0);
        cycles(1);

        // Illegal row, then illegal col: dropped with one-cycle error
        send(4'h2, 2'd0, 3'd5, 3'd0, 8'h12, 8'h34, 8'h00, 32'h0, 0);
        chk("t3_err", 32'(bus.cmd_err), 32'd1);
        chk("t3_count", 32'(bus.fifo_count), 32'd0);
        cycles(1);
        chk("t3_err_clear", 32'(bus.cmd_err), 32'd0);
        send(4'h3, 2'd1, 3'd4, 3'd6, 8'h12, 8'h34, 8'h00, 32'h0, 0);
        chk("t3b_err", 32'(bus.cmd_err), 32'd1);
        chk("t3b_valid", 32'(bus.instr_valid), 32'd0);
        cycles(1);

        // Fill to DEPTH with consumer stalled; boundary row/col = 4
        bus.instr_ready = 1'b0;
        send(4'h2, 2'd1, 3'd0, 3'd4, 8'h11, 8'h22, 8'h00, 32'h02211442, 1);
        chk("t4_hold", bus.instr, 32'h02211442);
        send(4'h3, 2'd3, 3'd4, 3'd0, 8'hFF, 8'h00, 8'h00, 32'h000FFE03, 1);
        send(4'h9, 2'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h55, 32'h00000559, 1);
        send(4'h7, 2'd0, 3'd2, 3'd2, 8'h01, 8'h80, 8'h00, 32'h08001127, 1);
        chk("t4_full_count", 32'(bus.fifo_count), 32'd4);
        chk("t4_full_ready", 32'(bus.cmd_ready), 32'd0);
        chk("t4_head_stable", bus.instr, 32'h02211442);
        bus.cmd_valid = 1'b1;
        cycles(3);
        chk("t4_no_overflow", 32'(bus.fifo_count), 32'd4);
        bus.cmd_valid = 1'b0;
        bus.instr_ready = 1'b1;
        cycles(1);
        chk("t4_decrement", 32'(bus.fifo_count), 32'd3);
        drain();

        // Steady state at two entries with simultaneous push and pop
        bus.instr_ready = 1'b0;
        send(4'hC, 2'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'hA0, 32'h00000A0C, 1);
        send(4'hC, 2'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'hA1, 32'h00000A1C, 1);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] s;
            s = 8'hB0 + 8'(i);
            send(4'hC, 2'd0, 3'd0, 3'd0, 8'h00, 8'h00, s,
                 {20'h0, s, 4'hC}, 1);
            chk("t5_count", 32'(bus.fifo_count), 32'd2);
        end
        drain();
        chk("t5_issued", 32'(bus.issued_cnt), 32'(pops));

        // Reset with three entries queued
        bus.instr_ready = 1'b0;
        send(4'h1, 2'd0, 3'd1, 3'd1, 8'h01, 8'h02, 8'h00, 32'h00201091, 1);
        send(4'h1, 2'd0, 3'd1, 3'd2, 8'h01, 8'h02, 8'h00, 32'h002010A1, 1);
        send(4'h1, 2'd0, 3'd1, 3'd3, 8'h01, 8'h02, 8'h00, 32'h002010B1, 1);
        chk("t6_pre_count", 32'(bus.fifo_count), 32'd3);
        reset = 1'b1;
        exp_q.delete();
        cycles(1);
        chk("t6_valid", 32'(bus.instr_valid), 32'd0);
        chk("t6_count", 32'(bus.fifo_count), 32'd0);
        chk("t6_issued", 32'(bus.issued_cnt), 32'd0);
        chk("t6_instr", bus.instr, 32'd0);
        reset = 1'b0;
        pops = 0;
        bus.instr_ready = 1'b1;
        cycles(2);
        chk("t6_no_issue", 32'(bus.issued_cnt), 32'd0);

        // Traffic resumes normally after reset
        send(4'h6, 2'd1, 3'd2, 3'd3, 8'h5A, 8'hA5, 8'h00, 32'h0A55A536, 1);
        cycles(2);
        chk("t7_issued", 32'(bus.issued_cnt), 32'd1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
